fetch_pair_splitter: RTL and testbench
======================================

# fetch_pair_splitter

Registered two-slot staging stage that sits directly upstream of the instruction-queue dual-ported FIFO. It accepts fetch packets of up to two instructions with a valid mask and compacts them so the oldest valid instruction is always in slot A. It drives the FIFO's two push ports in program order and holds the younger instruction when the FIFO has only one free entry. It runs at two instructions per cycle when the FIFO keeps up.

## Interface
- DW, 16, bits per instruction word (opaque payload: instruction plus any PC/tag bits)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- valid_flush  in  1  pipeline flush; same signal that flushes the downstream FIFO
- in_valid  in  1  fetch packet valid
- in_ready  out  1  packet accepted when in_valid & in_ready
- in_mask  in  2  bit0 = in_data_0 valid (older), bit1 = in_data_1 valid (younger)
- in_data_0  in  DW  older instruction
- in_data_1  in  DW  younger instruction
- push_1  out  1  push older staged instruction to FIFO port 1
- ready_1  in  1  FIFO has ≥1 free entry
- push_data_1  out  DW  slot A contents
- push_2  out  1  push younger staged instruction to FIFO port 2
- ready_2  in  1  FIFO has ≥2 free entries
- push_data_2  out  DW  slot B contents
- busy  out  1  count != 0

## Operation
- State is a 2-bit occupancy `count` ∈ {EMPTY=0, ONE=1, TWO=2}, plus registers slot_a and slot_b. Slot A is always older; slot B is valid only when count==TWO.
- Push generation is combinational from registers and readies:
  - push_1 = (count!=0) & ready_1 & ~valid_flush
  - push_2 = (count==TWO) & ready_2 & ~valid_flush
  - push_2 is never asserted without push_1.
  - push_data_1 = slot_a; push_data_2 = slot_b.
- Drain result:
  - drained_all = (count==0) | (count==ONE & push_1) | (count==TWO & push_2)
  - partial = count==TWO & push_1 & ~push_2. On partial: slot_a <= slot_b, count <= ONE.
- in_ready = drained_all & ~valid_flush.
- Accept (in_valid & in_ready) loads compacted slots and sets count from the mask:
  - mask 11 → A=d0, B=d1, TWO
  - mask 01 → A=d0, ONE
  - mask 10 → A=d1, ONE
  - mask 00 → packet consumed, count=EMPTY
- No accept and drained_all → count <= EMPTY.
- No push possible (ready_1=0) → state holds.
- valid_flush, highest priority after rst:
  - count <= EMPTY; pushes gated low that cycle; incoming packet is not accepted.
  - Slot data contents are don't-care.
- rst: count=EMPTY asynchronously. Slot data registers need no reset.

## Timing
- Latency: a packet accepted at edge N is pushed at the earliest in cycle N+1 (one register stage).
- Throughput: a new packet is accepted in the same cycle the stage fully drains, so two instructions per cycle are sustained with ready_2=1.
- in_ready depends combinationally on ready_1/ready_2. Upstream must not make in_valid depend on in_ready.
- Reset values (rst high, no flush): push_1=0, push_2=0, busy=0, in_ready=1.
- Boundaries:
  - count TWO with ready_1=1, ready_2=0: one push, B shifts to A, in_ready=0.
  - ready_1=0: zero pushes, in_ready=0 unless count==EMPTY.
  - flush coincident with in_valid: packet dropped; upstream sees in_ready=0 and must not retry after flush.
  - rst asserted mid-hold: held instruction is discarded and push outputs drop immediately.

## Structure
- Shared package:
  - count enum typedef {EMPTY, ONE, TWO} (2-bit)
  - mask encoding constants (MASK_OLD=2'b01, MASK_YOUNG=2'b10)
- No sub-module. Compaction is a small function placed in the package so the decode-side stages reuse it.

## Test plan
- Reset, then in_valid=1, mask=11, d0=0xAAAA, d1=0xBBBB, ready_1=ready_2=1 → next cycle push_1=push_2=1 with 0xAAAA/0xBBBB; in_ready stays 1. Back-to-back packets sustain 2 pushes/cycle.
- Count TWO with ready_2=0, ready_1=1 → cycle 1: push_1 only (0xAAAA), in_ready=0. Cycle 2: push_1 with 0xBBBB, in_ready=1.
- mask=10, d1=0x1234 → push_1=1, push_data_1=0x1234, push_2=0. mask=00 → no pushes, in_ready stays 1.
- ready_1=0 for 5 cycles with count=TWO → no pushes, in_ready=0, slot contents unchanged. Release → both pushed in order.
- valid_flush pulse with count=TWO and in_valid=1 → push_1=push_2=in_ready=0 that cycle. Next cycle busy=0 and nothing from the old or incoming packet is ever pushed.
- rst asserted asynchronously while holding one instruction → push_1 falls before the next clk edge. After release, busy=0 and in_ready=1.
- Assertion throughout: push_2 implies push_1. Scoreboard confirms every push order matches the input order.

Source files
------------

// File: rtl/fetch_pair_splitter_pkg.sv
// Shared types and helpers for the fetch staging / decode-side stages.
// Compaction is expressed as a slot-select decode so it is independent of payload width.
package fetch_pair_splitter_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } count_t;

   localparam logic [1:0] MASK_OLD   = 2'b01;
   localparam logic [1:0] MASK_YOUNG = 2'b10;

   typedef struct packed {
      count_t cnt;
      logic   a_sel_young;   // slot A takes the younger word (only old lane empty)
   } compact_t;

   function automatic compact_t compact(input logic [1:0] mask);
      compact_t c;
      c.cnt         = EMPTY;
      c.a_sel_young = 1'b0;
      case (mask)
         MASK_OLD | MASK_YOUNG: c.cnt = TWO;
         MASK_OLD:              c.cnt = ONE;
         MASK_YOUNG: begin
            c.cnt         = ONE;
            c.a_sel_young = 1'b1;
         end
         default:               c.cnt = EMPTY;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/fetch_pair_splitter.sv
// Two-slot staging register in front of the dual-push instruction FIFO.
// Keeps the oldest valid instruction in slot A and drains in program order.
module fetch_pair_splitter
   import fetch_pair_splitter_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    in_mask,
   input  logic [DW-1:0] in_data_0,
   input  logic [DW-1:0] in_data_1,
   output logic          push_1,
   input  logic          ready_1,
   output logic [DW-1:0] push_data_1,
   output logic          push_2,
   input  logic          ready_2,
   output logic [DW-1:0] push_data_2,
   output logic          busy
);

   count_t        count, count_n;
   logic [DW-1:0] slot_a, slot_b, slot_a_n, slot_b_n;
   logic          drained_all, partial, accept;
   compact_t      cmp;

   // push_2 also requires ready_1 so port 2 can never fire alone
   assign push_1      = (count != EMPTY) & ready_1 & ~valid_flush;
   assign push_2      = (count == TWO) & ready_1 & ready_2 & ~valid_flush;
   assign push_data_1 = slot_a;
   assign push_data_2 = slot_b;
   assign busy        = (count != EMPTY);

   assign drained_all = (count == EMPTY) | ((count == ONE) & push_1) | ((count == TWO) & push_2);
   assign partial     = (count == TWO) & push_1 & ~push_2;
   assign in_ready    = drained_all & ~valid_flush;
   assign accept      = in_valid & in_ready;
   assign cmp         = compact(in_mask);

   always_comb begin
      count_n  = count;
      slot_a_n = slot_a;
      slot_b_n = slot_b;
      if (valid_flush) begin
         count_n = EMPTY;
      end else if (accept) begin
         count_n  = cmp.cnt;
         slot_a_n = cmp.a_sel_young ? in_data_1 : in_data_0;
         slot_b_n = in_data_1;
      end else if (drained_all) begin
         count_n = EMPTY;
      end else if (partial) begin
         count_n  = ONE;
         slot_a_n = slot_b;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count <= EMPTY;
      else     count <= count_n;
   end

   // payload registers carry no reset; count qualifies them
   always_ff @(posedge clk) begin
      slot_a <= slot_a_n;
      slot_b <= slot_b_n;
   end

endmodule

// File: tb/tb_fetch_pair_splitter.sv
// Directed bench for fetch_pair_splitter with an in-order push scoreboard.
module tb_fetch_pair_splitter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_mask = 2'b00;
   logic [15:0] in_data_0 = '0, in_data_1 = '0;
   logic        push_1, push_2, busy;
   logic        ready_1 = 1'b1, ready_2 = 1'b1;
   logic [15:0] push_data_1, push_data_2;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] exp_q[$];

   fetch_pair_splitter #(.DW(16)) dut (
      .clk(clk), .rst(rst), .valid_flush(valid_flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
      .in_data_0(in_data_0), .in_data_1(in_data_1),
      .push_1(push_1), .ready_1(ready_1), .push_data_1(push_data_1),
      .push_2(push_2), .ready_2(ready_2), .push_data_2(push_data_2),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // drive one cycle's inputs at negedge, settle, then score this cycle's pushes
   task automatic step(input logic iv, input logic [1:0] m, input logic [15:0] a,
                       input logic [15:0] b, input logic r1, input logic r2, input logic fl);
      @(negedge clk);
      in_valid = iv; in_mask = m; in_data_0 = a; in_data_1 = b;
      ready_1 = r1; ready_2 = r2; valid_flush = fl;
      #1;
      chk("p2_implies_p1", {31'd0, push_2 & ~push_1}, 32'd0);
      if (push_1) begin
         if (exp_q.size() == 0) chk("sb_underflow_1", 32'd1, 32'd0);
         else chk("sb_order_1", {16'd0, push_data_1}, {16'd0, exp_q.pop_front()});
      end
      if (push_2) begin
         if (exp_q.size() == 0) chk("sb_underflow_2", 32'd1, 32'd0);
         else chk("sb_order_2", {16'd0, push_data_2}, {16'd0, exp_q.pop_front()});
      end
      if (fl) exp_q.delete();
      if (iv && in_ready && !fl) begin
         if (m[0]) exp_q.push_back(a);
         if (m[1]) exp_q.push_back(b);
      end
   endtask

   task automatic idle(input logic r1, input logic r2);
      step(1'b0, 2'b00, 16'h0, 16'h0, r1, r2, 1'b0);
   endtask

   initial begin
      // reset state
      @(negedge clk); #1;
      chk("rst_push_1", {31'd0, push_1}, 32'd0);
      chk("rst_push_2", {31'd0, push_2}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk); rst = 1'b0;

      // full-rate streaming
      step(1'b1, 2'b11, 16'hAAAA, 16'hBBBB, 1'b1, 1'b1, 1'b0);
      chk("s0_in_ready", {31'd0, in_ready}, 32'd1);
      chk("s0_push_1", {31'd0, push_1}, 32'd0);
      step(1'b1, 2'b11, 16'h1111, 16'h2222, 1'b1, 1'b1, 1'b0);
      chk("s1_push_1", {31'd0, push_1}, 32'd1);
      chk("s1_push_2", {31'd0, push_2}, 32'd1);
      chk("s1_data_1", {16'd0, push_data_1}, 32'hAAAA);
      chk("s1_data_2", {16'd0, push_data_2}, 32'hBBBB);
      chk("s1_in_ready", {31'd0, in_ready}, 32'd1);
      idle(1'b1, 1'b1);
      chk("s2_push_2", {31'd0, push_2}, 32'd1);
      chk("s2_data_1", {16'd0, push_data_1}, 32'h1111);
      chk("s2_data_2", {16'd0, push_data_2}, 32'h2222);
      idle(1'b1, 1'b1);
      chk("s3_busy", {31'd0, busy}, 32'd0);

      // only one free FIFO entry: B shifts into A
      step(1'b1, 2'b11, 16'hAAAA, 16'hBBBB, 1'b1, 1'b1, 1'b0);
      idle(1'b1, 1'b0);
      chk("p0_push_1", {31'd0, push_1}, 32'd1);
      chk("p0_push_2", {31'd0, push_2}, 32'd0);
      chk("p0_data_1", {16'd0, push_data_1}, 32'hAAAA);
      chk("p0_in_ready", {31'd0, in_ready}, 32'd0);
      idle(1'b1, 1'b0);
      chk("p1_push_1", {31'd0, push_1}, 32'd1);
      chk("p1_push_2", {31'd0, push_2}, 32'd0);
      chk("p1_data_1", {16'd0, push_data_1}, 32'hBBBB);
      chk("p1_in_ready", {31'd0, in_ready}, 32'd1);

      // younger-only and empty masks
      step(1'b1, 2'b10, 16'hDEAD, 16'h1234, 1'b1, 1'b1, 1'b0);
      step(1'b1, 2'b00, 16'hFFFF, 16'hEEEE, 1'b1, 1'b1, 1'b0);
      chk("m10_push_1", {31'd0, push_1}, 32'd1);
      chk("m10_data_1", {16'd0, push_data_1}, 32'h1234);
      chk("m10_push_2", {31'd0, push_2}, 32'd0);
      chk("m10_in_ready", {31'd0, in_ready}, 32'd1);
      idle(1'b1, 1'b1);
      chk("m00_push_1", {31'd0, push_1}, 32'd0);
      chk("m00_busy", {31'd0, busy}, 32'd0);
      chk("m00_in_ready", {31'd0, in_ready}, 32'd1);
      step(1'b1, 2'b01, 16'h7777, 16'h8888, 1'b1, 1'b1, 1'b0);
      idle(1'b1, 1'b1);
      chk("m01_data_1", {16'd0, push_data_1}, 32'h7777);
      chk("m01_push_2", {31'd0, push_2}, 32'd0);

      // FIFO full for 5 cycles while holding two
      step(1'b1, 2'b11, 16'h5555, 16'h6666, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 2'b11, 16'h9999, 16'h9999, 1'b0, 1'b1, 1'b0);
         chk("hold_push_1", {31'd0, push_1}, 32'd0);
         chk("hold_push_2", {31'd0, push_2}, 32'd0);
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         chk("hold_data_1", {16'd0, push_data_1}, 32'h5555);
         chk("hold_data_2", {16'd0, push_data_2}, 32'h6666);
      end
      idle(1'b1, 1'b1);
      chk("rel_push_2", {31'd0, push_2}, 32'd1);
      chk("rel_data_1", {16'd0, push_data_1}, 32'h5555);
      chk("rel_data_2", {16'd0, push_data_2}, 32'h6666);

      // flush with staged pair and an incoming packet
      step(1'b1, 2'b11, 16'hA1A1, 16'hB1B1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 2'b11, 16'hC1C1, 16'hD1D1, 1'b1, 1'b1, 1'b1);
      chk("fl_push_1", {31'd0, push_1}, 32'd0);
      chk("fl_push_2", {31'd0, push_2}, 32'd0);
      chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
      idle(1'b1, 1'b1);
      chk("fl_busy_after", {31'd0, busy}, 32'd0);
      chk("fl_push_after", {31'd0, push_1}, 32'd0);
      idle(1'b1, 1'b1);

      // async reset while holding one instruction
      step(1'b1, 2'b01, 16'h4242, 16'h0, 1'b1, 1'b1, 1'b0);
      idle(1'b0, 1'b1);
      chk("ar_hold_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0; ready_1 = 1'b1; #1;
      chk("ar_push_pre", {31'd0, push_1}, 32'd1);
      chk("ar_data_pre", {16'd0, push_data_1}, 32'h4242);
      #1 rst = 1'b1;
      #1;
      chk("ar_push_drop", {31'd0, push_1}, 32'd0);
      chk("ar_busy_drop", {31'd0, busy}, 32'd0);
      exp_q.delete();
      @(negedge clk); rst = 1'b0; #1;
      chk("ar_busy_post", {31'd0, busy}, 32'd0);
      chk("ar_in_ready_post", {31'd0, in_ready}, 32'd1);
      idle(1'b1, 1'b1);
      chk("ar_no_push", {31'd0, push_1}, 32'd0);

      chk("sb_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
